// File: rtl/fp_mul_pkg.sv
// Shared types for the FP multiplier arbiter: operand/result types and the in-flight tag.
package fp_mul_pkg;
    localparam int FP_W  = 32;
    localparam int RM_W  = 4;
    // Tag index is sized for the largest supported requester count (8).
    localparam int IDX_W = 3;

    typedef logic [FP_W-1:0] fp_t;

    typedef struct packed {
        fp_t  z;
        logic ovrf;
        logic udrf;
    } mul_res_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } mul_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr_i (with wrap) wins.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);
    int c;

    // Scan offsets from far to near so the nearest request to ptr_i is written last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        c       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr_i) + k) % N;
            if (req_i[c]) begin
                grant_o    = '0;
                grant_o[c] = 1'b1;
                idx_o      = IW'(c);
            end
        end
    end
endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one fixed-latency FP multiplier among N_REQ requesters; each accepted op is tagged
// with its requester and the result lands in that requester's response slot.
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*FP_W-1:0]  req_x,
    input  logic [N_REQ*FP_W-1:0]  req_y,
    input  logic [N_REQ*RM_W-1:0]  req_rmode,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [N_REQ*FP_W-1:0]  rsp_z,
    output logic [N_REQ-1:0]       rsp_ovrf,
    output logic [N_REQ-1:0]       rsp_udrf,
    output logic [RM_W-1:0]        mul_r_mode,
    output logic [FP_W-1:0]        mul_fp_X,
    output logic [FP_W-1:0]        mul_fp_Y,
    input  logic [FP_W-1:0]        mul_fp_Z,
    input  logic                   mul_ovrf,
    input  logic                   mul_udrf
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
    logic [N_REQ-1:0] busy_q, busy_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] elig, grant, cap_oh;
    logic [IW-1:0]    win;
    logic             accept;
    mul_tag_t         tag_q [MUL_LAT+1];
    mul_tag_t         cap;
    mul_res_t         res_q [N_REQ];
    fp_t              x_q, y_q;
    logic [RM_W-1:0]  rm_q;

    assign elig = req_valid & ~busy_q;

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win)
    );

    assign req_ready = rst_n ? grant : '0;
    assign accept    = |grant;
    assign cap       = tag_q[MUL_LAT];

    always_comb begin
        cap_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cap.vld && int'(cap.idx) == i) cap_oh[i] = 1'b1;
        end
    end

    always_comb begin
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        ptr_d       = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (rsp_valid_q[i] && rsp_ready[i]) begin
                busy_d[i]      = 1'b0;
                rsp_valid_d[i] = 1'b0;
            end
            if (cap_oh[i]) rsp_valid_d[i] = 1'b1;
        end
        if (accept) begin
            busy_d[win] = 1'b1;
            ptr_d       = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            ptr_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rm_q        <= '0;
            for (int s = 0; s <= MUL_LAT; s++) tag_q[s] <= '0;
            for (int i = 0; i < N_REQ; i++) res_q[i] <= '0;
        end else begin
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            ptr_q       <= ptr_d;
            tag_q[0]    <= '{vld: accept, idx: IDX_W'(win)};
            for (int s = 1; s <= MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
            if (accept) begin
                x_q  <= req_x[win*FP_W +: FP_W];
                y_q  <= req_y[win*FP_W +: FP_W];
                rm_q <= req_rmode[win*RM_W +: RM_W];
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (cap_oh[i]) res_q[i] <= '{z: mul_fp_Z, ovrf: mul_ovrf, udrf: mul_udrf};
            end
        end
    end

    assign mul_fp_X   = x_q;
    assign mul_fp_Y   = y_q;
    assign mul_r_mode = rm_q;
    assign rsp_valid  = rsp_valid_q;

    for (genvar g = 0; g < N_REQ; g++) begin : g_rsp
        assign rsp_z[g*FP_W +: FP_W] = res_q[g].z;
        assign rsp_ovrf[g]           = res_q[g].ovrf;
        assign rsp_udrf[g]           = res_q[g].udrf;
    end

    // One outstanding op per requester means a capture can never hit a full slot.
    capture_slot_free: assert property (@(posedge clk) disable iff (!rst_n)
        !(|(cap_oh & rsp_valid_q)))
        else $fatal(1, "fp_mul_arbiter: result captured into an occupied slot");
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: behavioural FP multiplier, reference arbiter model and
// an in-order capture scoreboard.
module tb_fp_mul_arbiter;
  localparam int N   = 4;
  localparam int FW  = 32;
  localparam int RW  = 4;
  localparam int LAT = 2;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  idx;
    logic [33:0] val;
  } exp_t;

  logic            clk, rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_ovrf, rsp_udrf;
  logic [N*FW-1:0] req_x, req_y, rsp_z;
  logic [N*RW-1:0] req_rmode;
  logic [RW-1:0]   mul_r_mode;
  logic [FW-1:0]   mul_fp_X, mul_fp_Y, mul_fp_Z;
  logic            mul_ovrf, mul_udrf;

  int n_tests, n_fail, cyc, n_acc, n_rsp, ops_left;
  exp_t exp_q[$];
  logic [N-1:0] busy_m, vprev, acc_nxt, ld_mask;
  int ptr_m;
  logic [33:0] held [N];
  logic rand_on, rand_rsp;

  fp_mul_arbiter #(.N_REQ(N), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf),
    .mul_r_mode(mul_r_mode), .mul_fp_X(mul_fp_X), .mul_fp_Y(mul_fp_Y),
    .mul_fp_Z(mul_fp_Z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference multiplier: r_mode 0 rounds to nearest even, anything else truncates.
  // Zero/denormal inputs flush to zero; results out of range set ovrf/udrf.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] rm);
    logic s, g, st;
    int e;
    logic [47:0] p;
    logic [24:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1; m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0];
    end else begin
      m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
    end
    if (rm == 4'd0 && g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], m[22:0]};
  endfunction

  // Two-stage multiplier pipeline: result stable two edges after operands.
  logic [33:0] mp1, mp2;
  always @(posedge clk) begin
    mp1 <= fmul(mul_fp_X, mul_fp_Y, mul_r_mode);
    mp2 <= mp1;
  end
  assign {mul_ovrf, mul_udrf, mul_fp_Z} = mp2;

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(64, 190));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    busy_m = '0; ptr_m = 0; vprev = '0; acc_nxt = '0;
  endtask

  // Scoreboard / reference arbiter, run once per cycle at the falling edge.
  task automatic monitor();
    logic [N-1:0] eg, acc, rise;
    exp_t e;
    int c;
    eg = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = (ptr_m + k) % N;
      if (req_valid[c] && !busy_m[c]) begin eg = '0; eg[c] = 1'b1; end
    end
    check("grant", 64'(req_ready), 64'(eg));
    acc = req_valid & req_ready;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        e.cyc = 32'(cyc + 1);
        e.idx = 8'(i);
        e.val = fmul(req_x[i*FW +: FW], req_y[i*FW +: FW], req_rmode[i*RW +: RW]);
        exp_q.push_back(e);
        busy_m[i] = 1'b1;
        ptr_m = (i + 1) % N;
        n_acc++;
      end
    end
    acc_nxt = acc;
    rise = rsp_valid & ~vprev;
    for (int i = 0; i < N; i++) begin
      if (rise[i]) begin
        n_rsp++;
        if (exp_q.size() == 0) check("spurious_rsp", 64'(i), 64'hFF);
        else begin
          e = exp_q.pop_front();
          check("rsp_idx", 64'(i), 64'(e.idx));
          check("rsp_val", {rsp_ovrf[i], rsp_udrf[i], rsp_z[i*FW +: FW]}, 64'(e.val));
          check("rsp_lat", 64'(cyc - int'(e.cyc)), 64'(LAT + 1));
          held[i] = e.val;
        end
      end else if (vprev[i] && rsp_valid[i]) begin
        check("rsp_hold", {rsp_ovrf[i], rsp_udrf[i], rsp_z[i*FW +: FW]}, 64'(held[i]));
      end
    end
    if (exp_q.size() > 0 && cyc - int'(exp_q[0].cyc) > LAT + 1) begin
      check("rsp_timeout", 64'(cyc - int'(exp_q[0].cyc)), 64'(LAT + 1));
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < N; i++) if (rsp_valid[i] && rsp_ready[i]) busy_m[i] = 1'b0;
    vprev = rsp_valid;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    req_valid = req_valid & ~acc_nxt;
    acc_nxt = '0;
    if (rand_on) begin
      for (int i = 0; i < N; i++) begin
        if (ld_mask[i] && !req_valid[i] && ops_left > 0 && $urandom_range(0, 3) != 0) begin
          req_x[i*FW +: FW]     = rand_fp();
          req_y[i*FW +: FW]     = rand_fp();
          req_rmode[i*RW +: RW] = 4'($urandom_range(0, 1) * $urandom_range(1, 15));
          req_valid[i]          = 1'b1;
          ops_left--;
        end
      end
    end
    if (rand_rsp) for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input int i, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] rm);
    req_x[i*FW +: FW]     = x;
    req_y[i*FW +: FW]     = y;
    req_rmode[i*RW +: RW] = rm;
    req_valid[i]          = 1'b1;
  endtask

  task automatic wait_acc(input int i);
    for (int c = 0; c < 20 && req_valid[i]; c++) step();
    if (req_valid[i]) check("acc_timeout", 64'(i), 64'hFF);
  endtask

  task automatic wait_rsp(input int i);
    for (int c = 0; c < 20 && !rsp_valid[i]; c++) step();
    check("rsp_wait", 64'(rsp_valid[i]), 64'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0;
    rand_on = 1'b0; rand_rsp = 1'b0; ld_mask = '0;
    flush_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int acc0, rsp0;
    n_tests = 0; n_fail = 0; cyc = 0; n_acc = 0; n_rsp = 0; ops_left = 0;
    req_x = '0; req_y = '0; req_rmode = '0;
    for (int i = 0; i < N; i++) held[i] = '0;
    apply_reset();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mul_x", 64'(mul_fp_X), 64'd0);
    check("rst_mul_y", 64'(mul_fp_Y), 64'd0);
    check("rst_mul_rm", 64'(mul_r_mode), 64'd0);
    check("rst_rsp_z", 64'(|rsp_z), 64'd0);
    check("rst_flags", 64'(|{rsp_ovrf, rsp_udrf}), 64'd0);

    // 1: single op on requester 0
    drive(0, 32'h3FC00000, 32'h40000000, 4'h5);
    wait_acc(0);
    check("t1_mul_x", 64'(mul_fp_X), 64'h3FC00000);
    check("t1_mul_y", 64'(mul_fp_Y), 64'h40000000);
    check("t1_mul_rm", 64'(mul_r_mode), 64'h5);
    wait_rsp(0);
    check("t1_z", 64'(rsp_z[31:0]), 64'h40400000);
    check("t1_flags", 64'({rsp_ovrf[0], rsp_udrf[0]}), 64'd0);
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    repeat (2) step();
    check("t1_rsp_done", 64'(rsp_valid), 64'd0);

    // 2: all four at once from ptr 0
    apply_reset();
    rsp_ready = '1;
    for (int i = 0; i < N; i++) drive(i, 32'h3F800000 + 32'(i << 20), 32'h40400000 - 32'(i << 19), 4'(i));
    for (int s = 0; s < N; s++) begin
      step();
      check("t2_order", 64'(req_valid), 64'(4'(4'b1110 << s)));
    end
    repeat (8) step();
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: requester 1 backpressured while the others stream
    apply_reset();
    rsp_ready = 4'b1101;
    drive(1, 32'h40490FDB, 32'h3F000000, 4'h0);
    wait_acc(1);
    wait_rsp(1);
    rand_on = 1'b1; ld_mask = 4'b1101; ops_left = 1000;
    acc0 = n_acc;
    repeat (20) step();
    check("t3_valid1", 64'(rsp_valid[1]), 64'd1);
    check("t3_z1", 64'(rsp_z[FW +: FW]), 64'(fmul(32'h40490FDB, 32'h3F000000, 4'h0)));
    check("t3_stream", 64'((n_acc - acc0) >= 3), 64'd1);
    rand_on = 1'b0; rsp_ready = '1;
    repeat (20) step();
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // 4: overflow and underflow flags
    apply_reset();
    drive(2, 32'h7F7FFFFF, 32'h40000000, 4'h0);
    drive(3, 32'h00800000, 32'h00800000, 4'h0);
    wait_acc(2);
    wait_acc(3);
    wait_rsp(3);
    check("t4_ovrf2", 64'({rsp_ovrf[2], rsp_udrf[2]}), 64'b10);
    check("t4_z2", 64'(rsp_z[2*FW +: FW]), 64'h7F800000);
    check("t4_udrf3", 64'({rsp_ovrf[3], rsp_udrf[3]}), 64'b01);
    check("t4_z3", 64'(rsp_z[3*FW +: FW]), 64'd0);
    rsp_ready = '1;
    repeat (4) step();

    // 5: reset with three ops in flight
    apply_reset();
    rsp_ready = '1;
    drive(0, 32'h3F800000, 32'h3F800000, 4'h0);
    drive(1, 32'h40000000, 32'h40000000, 4'h0);
    drive(2, 32'h40400000, 32'h40400000, 4'h0);
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    check("t5_outs_zero", 64'(|{req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf,
                                 mul_r_mode, mul_fp_X, mul_fp_Y}), 64'd0);
    req_valid = '0;
    flush_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) step();
    check("t5_no_rsp", 64'(rsp_valid), 64'd0);

    // 6: random traffic and response backpressure
    apply_reset();
    rand_on = 1'b1; rand_rsp = 1'b1; ld_mask = '1; ops_left = 10000;
    acc0 = n_acc; rsp0 = n_rsp;
    for (int c = 0; c < 80000 && (n_acc - acc0) < 10000; c++) step();
    rand_on = 1'b0; rand_rsp = 1'b0; rsp_ready = '1;
    repeat (20) step();
    check("t6_acc", 64'(n_acc - acc0), 64'd10000);
    check("t6_rsp", 64'(n_rsp - rsp0), 64'(n_acc - acc0));
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
